// File: rtl/cmp_window_pkg.sv
// Shared zone encoding and helpers for the window comparator slice.
package cmp_pkg;

    typedef logic [1:0] zone_t;

    localparam zone_t ZONE_BELOW  = 2'b00;
    localparam zone_t ZONE_INSIDE = 2'b01;
    localparam zone_t ZONE_ABOVE  = 2'b10;
    localparam zone_t ZONE_RESET  = ZONE_INSIDE;

    function automatic zone_t raw_zone(input logic lt, input logic gt);
        zone_t z;
        z = ZONE_INSIDE;
        unique case (1'b1)
            lt:      z = ZONE_BELOW;
            gt:      z = ZONE_ABOVE;
            default: z = ZONE_INSIDE;
        endcase
        return z;
    endfunction

endpackage

// File: rtl/cmp_window_if.sv
// Sample stream in, raw compare and debounced zone out.
interface cmp_window_if #(
    parameter int WIDTH = 8
);
    import cmp_pkg::*;

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] lo_thr;
    logic [WIDTH-1:0] hi_thr;
    logic             out_valid;
    logic             raw_lt;
    logic             raw_gt;
    logic             raw_in;
    zone_t            zone;
    logic             zone_chg;
    logic             cfg_err;

    modport master (
        output in_valid, in_data, lo_thr, hi_thr,
        input  out_valid, raw_lt, raw_gt, raw_in,
        input  zone, zone_chg, cfg_err
    );

    modport slave (
        input  in_valid, in_data, lo_thr, hi_thr,
        output out_valid, raw_lt, raw_gt, raw_in,
        output zone, zone_chg, cfg_err
    );

endinterface

// File: rtl/cmp_window_debounce.sv
// Zone debouncer; counter/candidate logic only with CMP_WINDOW_DEBOUNCE_EN.
module cmp_debounce
    import cmp_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  valid,
    input  zone_t raw,
    output zone_t zone,
    output logic  zone_chg
);

    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("cmp_debounce: DEBOUNCE must be >= 1");
    end

    zone_t zone_q;
    logic  chg_q;

`ifdef CMP_WINDOW_DEBOUNCE_EN

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE);

    logic [CW-1:0] cnt_q, cnt_d;
    zone_t         cand_q, cand_d;
    zone_t         zone_d;
    logic          chg_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zone_q <= ZONE_RESET;
            chg_q  <= 1'b0;
            cnt_q  <= '0;
            cand_q <= ZONE_RESET;
        end else begin
            zone_q <= zone_d;
            chg_q  <= chg_d;
            cnt_q  <= cnt_d;
            cand_q <= cand_d;
        end
    end

    always_comb begin
        zone_d = zone_q;
        chg_d  = 1'b0;
        cnt_d  = cnt_q;
        cand_d = cand_q;
        if (valid) begin
            if (raw == zone_q) begin
                cnt_d  = '0;
                cand_d = ZONE_RESET;
            end else begin
                if (raw == cand_q) begin
                    cnt_d = (cnt_q == LIMIT) ? LIMIT : cnt_q + 1'b1;
                end else begin
                    cand_d = raw;
                    cnt_d  = CW'(1);
                end
                // Accept on the same edge the count is reached.
                if (cnt_d == LIMIT) begin
                    zone_d = raw;
                    chg_d  = 1'b1;
                    cnt_d  = '0;
                end
            end
        end
    end

`else

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zone_q <= ZONE_RESET;
            chg_q  <= 1'b0;
        end else if (valid) begin
            zone_q <= raw;
            chg_q  <= (raw != zone_q);
        end else begin
            chg_q  <= 1'b0;
        end
    end

`endif

    assign zone     = zone_q;
    assign zone_chg = chg_q;

endmodule

// File: rtl/cmp_window.sv
// Pipelined window comparator with debounced zone tracking.
// Debounce counter is built only when CMP_WINDOW_DEBOUNCE_EN is defined.
module cmp_window
    import cmp_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SIGNED   = 0,
    parameter int DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         rst,
    cmp_window_if.slave  bus
);

    if (WIDTH < 2) begin : g_bad_width
        $error("cmp_window: WIDTH must be >= 2");
    end

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [WIDTH-1:0] s1_lo;
    logic [WIDTH-1:0] s1_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_lo    <= '0;
            s1_hi    <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data <= bus.in_data;
                s1_lo   <= bus.lo_thr;
                s1_hi   <= bus.hi_thr;
            end
        end
    end

    logic lt;
    logic gt;
    logic bad;

    if (SIGNED != 0) begin : g_signed
        assign lt  = $signed(s1_data) < $signed(s1_lo);
        assign gt  = $signed(s1_data) > $signed(s1_hi);
        assign bad = $signed(s1_lo) > $signed(s1_hi);
    end else begin : g_unsigned
        assign lt  = s1_data < s1_lo;
        assign gt  = s1_data > s1_hi;
        assign bad = s1_lo > s1_hi;
    end

    logic out_valid;
    logic raw_lt;
    logic raw_gt;
    logic raw_in;
    logic cfg_err;

    // cfg_err is sticky between samples; raw flags are zero on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            raw_lt    <= 1'b0;
            raw_gt    <= 1'b0;
            raw_in    <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (s1_valid) begin
            out_valid <= 1'b1;
            raw_lt    <= lt & ~bad;
            raw_gt    <= gt & ~bad;
            raw_in    <= ~lt & ~gt & ~bad;
            cfg_err   <= bad;
        end else begin
            out_valid <= 1'b0;
            raw_lt    <= 1'b0;
            raw_gt    <= 1'b0;
            raw_in    <= 1'b0;
        end
    end

    zone_t zone;
    logic  zone_chg;

    cmp_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .valid    (out_valid & ~cfg_err),
        .raw      (raw_zone(raw_lt, raw_gt)),
        .zone     (zone),
        .zone_chg (zone_chg)
    );

    assign bus.out_valid = out_valid;
    assign bus.raw_lt    = raw_lt;
    assign bus.raw_gt    = raw_gt;
    assign bus.raw_in    = raw_in;
    assign bus.cfg_err   = cfg_err;
    assign bus.zone      = zone;
    assign bus.zone_chg  = zone_chg;

endmodule

// File: tb/tb_cmp_window.sv
// Bench for cmp_window: unsigned and signed instances fed identical streams.
module tb_cmp_window;

`ifdef CMP_WINDOW_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif

    typedef struct {
        bit         v;
        logic [7:0] d;
        logic [7:0] lo;
        logic [7:0] hi;
    } smp_t;

    logic clk;
    logic rst;

    cmp_window_if #(.WIDTH(8)) bu ();
    cmp_window_if #(.WIDTH(8)) bs ();

    cmp_window #(.WIDTH(8), .SIGNED(0), .DEBOUNCE(4)) u_dut_u (
        .clk (clk),
        .rst (rst),
        .bus (bu)
    );

    cmp_window #(.WIDTH(8), .SIGNED(1), .DEBOUNCE(4)) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   stepno = 0;
    smp_t pipe[$];
    int   mzone[2];
    int   mcfg[2];
    int   mchg[2];
    int   hw[2][4];
    int   hn[2];

    // 0 below, 1 inside, 2 above, 3 threshold error
    function automatic int rawz(input bit s, input logic [7:0] d,
                                input logic [7:0] lo, input logic [7:0] hi);
        int dv, lv, hv;
        if (s) begin
            dv = int'($signed(d));
            lv = int'($signed(lo));
            hv = int'($signed(hi));
        end else begin
            dv = int'(d);
            lv = int'(lo);
            hv = int'(hi);
        end
        if (lv > hv) return 3;
        if (dv < lv) return 0;
        if (dv > hv) return 2;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < 2; i++) begin
            mzone[i] = 1;
            mcfg[i]  = 0;
            mchg[i]  = 0;
            hn[i]    = 0;
        end
    endtask

    task automatic check_dut(input int i, input int ov, input int lt,
                             input int gt, input int in);
        logic [7:0] o_v, o_lt, o_gt, o_in, o_cfg, o_z, o_c;
        string sfx;
        if (i == 0) begin
            o_v = 8'(bu.out_valid); o_lt = 8'(bu.raw_lt);
            o_gt = 8'(bu.raw_gt); o_in = 8'(bu.raw_in);
            o_cfg = 8'(bu.cfg_err); o_z = 8'(bu.zone);
            o_c = 8'(bu.zone_chg);
        end else begin
            o_v = 8'(bs.out_valid); o_lt = 8'(bs.raw_lt);
            o_gt = 8'(bs.raw_gt); o_in = 8'(bs.raw_in);
            o_cfg = 8'(bs.cfg_err); o_z = 8'(bs.zone);
            o_c = 8'(bs.zone_chg);
        end
        sfx = $sformatf("[%s]@%0d", (i == 0) ? "u" : "s", stepno);
        chk({"out_valid", sfx}, o_v, 8'(ov));
        chk({"raw_lt", sfx}, o_lt, 8'(lt));
        chk({"raw_gt", sfx}, o_gt, 8'(gt));
        chk({"raw_in", sfx}, o_in, 8'(in));
        chk({"cfg_err", sfx}, o_cfg, 8'(mcfg[i]));
        chk({"zone", sfx}, o_z, 8'(mzone[i]));
        chk({"zone_chg", sfx}, o_c, 8'(mchg[i]));
    endtask

    task automatic step(input bit v, input logic [7:0] d,
                        input logic [7:0] lo, input logic [7:0] hi);
        smp_t e;
        int   r, n, ov, lt, gt, in;
        bit   same;
        @(negedge clk);
        bu.in_valid = v; bu.in_data = d; bu.lo_thr = lo; bu.hi_thr = hi;
        bs.in_valid = v; bs.in_data = d; bs.lo_thr = lo; bs.hi_thr = hi;
        e.v = v; e.d = d; e.lo = lo; e.hi = hi;
        pipe.push_back(e);
        if (pipe.size() > 3) void'(pipe.pop_front());
        @(posedge clk);
        #1;
        stepno++;
        n = pipe.size();
        for (int i = 0; i < 2; i++) begin
            ov = 0; lt = 0; gt = 0; in = 0;
            if (n >= 2 && pipe[n-2].v) begin
                r  = rawz(i[0], pipe[n-2].d, pipe[n-2].lo, pipe[n-2].hi);
                ov = 1;
                lt = int'(r == 0);
                in = int'(r == 1);
                gt = int'(r == 2);
                mcfg[i] = int'(r == 3);
            end
            mchg[i] = 0;
            if (n >= 3 && pipe[n-3].v) begin
                r = rawz(i[0], pipe[n-3].d, pipe[n-3].lo, pipe[n-3].hi);
                if (r != 3) begin
                    for (int k = 0; k < D - 1; k++) hw[i][k] = hw[i][k+1];
                    hw[i][D-1] = r;
                    if (hn[i] < D) hn[i]++;
                    if (hn[i] == D) begin
                        same = 1'b1;
                        for (int k = 0; k < D; k++)
                            if (hw[i][k] != r) same = 1'b0;
                        if (same && r != mzone[i]) begin
                            mzone[i] = r;
                            mchg[i]  = 1;
                            hn[i]    = 0;
                        end
                    end
                end
            end
            check_dut(i, ov, lt, gt, in);
        end
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) step(1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bu.in_valid = 1'b0;
        bs.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        stepno++;
        for (int i = 0; i < 2; i++) check_dut(i, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] d, lo, hi;
        int region, len;
        rst = 1'b1;
        bu.in_valid = 1'b0; bu.in_data = '0; bu.lo_thr = '0; bu.hi_thr = '0;
        bs.in_valid = 1'b0; bs.in_data = '0; bs.lo_thr = '0; bs.hi_thr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_dut(i, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // unsigned window 0x20..0xE0, edges inclusive
        step(1, 8'h10, 8'h20, 8'hE0);
        step(1, 8'h20, 8'h20, 8'hE0);
        step(1, 8'hE0, 8'h20, 8'hE0);
        step(1, 8'hF0, 8'h20, 8'hE0);
        idle(3);

        // signed window -16..16
        step(1, 8'h80, 8'hF0, 8'h10);
        step(1, 8'h05, 8'hF0, 8'h10);
        step(1, 8'h7F, 8'hF0, 8'h10);
        idle(3);

        // three above then inside, then four above
        for (int k = 0; k < 3; k++) step(1, 8'hF0, 8'h20, 8'hE0);
        step(1, 8'h80, 8'h20, 8'hE0);
        for (int k = 0; k < 4; k++) step(1, 8'hF0, 8'h20, 8'hE0);
        idle(3);

        // gaps between valid samples
        step(1, 8'h80, 8'h20, 8'hE0);
        step(1, 8'h80, 8'h20, 8'hE0);
        idle(5);
        step(1, 8'h80, 8'h20, 8'hE0);
        step(1, 8'h80, 8'h20, 8'hE0);
        idle(3);

        // candidate switch above -> below
        step(1, 8'hF0, 8'h20, 8'hE0);
        for (int k = 0; k < 4; k++) step(1, 8'h10, 8'h20, 8'hE0);
        idle(3);

        // threshold error holds the count
        step(1, 8'hF0, 8'h20, 8'hE0);
        step(1, 8'hF0, 8'h20, 8'hE0);
        step(1, 8'h60, 8'h80, 8'h40);
        step(1, 8'h60, 8'h80, 8'h40);
        idle(2);
        step(1, 8'hF0, 8'h20, 8'hE0);
        step(1, 8'hF0, 8'h20, 8'hE0);
        idle(3);

        // reset with samples in flight
        for (int k = 0; k < 3; k++) step(1, 8'h10, 8'h20, 8'hE0);
        do_reset();
        step(1, 8'hF0, 8'h20, 8'hE0);
        idle(3);

        // random runs, unsigned-friendly thresholds
        for (int b = 0; b < 60; b++) begin
            region = $urandom_range(0, 2);
            len    = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                lo = 8'h20; hi = 8'hE0;
                if ($urandom_range(0, 19) == 0) begin lo = 8'hE0; hi = 8'h20; end
                case (region)
                    0:       d = 8'($urandom_range(8'h00, 8'h1F));
                    1:       d = 8'($urandom_range(8'h20, 8'hE0));
                    default: d = 8'($urandom_range(8'hE1, 8'hFF));
                endcase
                step($urandom_range(0, 9) < 8, d, lo, hi);
            end
        end

        // random runs, signed-friendly thresholds
        for (int b = 0; b < 60; b++) begin
            region = $urandom_range(0, 2);
            len    = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                lo = 8'hF0; hi = 8'h10;
                if ($urandom_range(0, 19) == 0) begin
                    lo = 8'($urandom); hi = 8'($urandom);
                end
                case (region)
                    0:       d = 8'($urandom_range(8'h80, 8'hEF));
                    1:       d = 8'($urandom_range(8'h00, 8'h20)) - 8'h10;
                    default: d = 8'($urandom_range(8'h11, 8'h7F));
                endcase
                step($urandom_range(0, 9) < 8, d, lo, hi);
            end
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_window.md
# cmp_window

Parametrised, pipelined window comparator with debounced zone tracking. Each valid sample is compared against a programmable low/high threshold pair and classified as below, inside or above the window. A stable zone output and a one-cycle zone-change pulse are produced for downstream alarm and threshold logic. It supersedes the fixed 8-bit combinational magnitude compare and adds width/sign generality, registered outputs, stream qualification and glitch rejection.

## Interface
- WIDTH, 8: sample and threshold width in bits (≥2).
- SIGNED, 0: 1 = two's-complement compare, 0 = unsigned compare.
- DEBOUNCE, 4: consecutive valid samples required to accept a new zone (≥1).
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset; asynchronous and active-high.
- in_valid  input  1  sample qualifier; no backpressure.
- in_data  input  WIDTH  sample.
- lo_thr  input  WIDTH  lower window bound, inclusive.
- hi_thr  input  WIDTH  upper window bound, inclusive.
- out_valid  output  1  raw-compare results valid.
- raw_lt  output  1  sample < lo_thr.
- raw_gt  output  1  sample > hi_thr.
- raw_in  output  1  lo_thr ≤ sample ≤ hi_thr.
- zone  output  2  debounced zone: 00 below, 01 inside, 10 above; 11 never driven.
- zone_chg  output  1  one-cycle pulse when zone updates.
- cfg_err  output  1  lo_thr > hi_thr on the last accepted sample.

## Operation
- Stage 1, on in_valid: register in_data, lo_thr and hi_thr together. Thresholds therefore apply per sample, and a threshold change affects only samples accepted on or after that edge.
- Stage 2: compute lt = data<lo and gt = data>hi. Use $signed when SIGNED=1 and a plain unsigned compare otherwise. No width extension; all operands are WIDTH bits.
- Raw zone: below if lt, above if gt, otherwise inside. Exactly one of raw_lt/raw_gt/raw_in is high while out_valid=1. All three are 0 while out_valid=0.
- cfg_err (lo>hi): set raw_lt=raw_gt=raw_in=0 and hold cfg_err=1. The sample is not fed to the debouncer, and the debounce counter is held.
- Debounce, on each out_valid sample with cfg_err=0:
  - raw == zone: clear the counter and candidate.
  - raw ≠ zone and raw == candidate: increment the counter, saturating at DEBOUNCE.
  - raw ≠ zone and raw ≠ candidate: set candidate = raw and counter = 1.
  - Counter reaches DEBOUNCE: update zone to candidate on the same edge, pulse zone_chg, clear the counter.
- Cycles with out_valid=0 neither advance nor clear the counter.
- DEBOUNCE=1: zone follows raw on every valid sample.
- Direct below↔above transitions are allowed; the zone need not pass through inside.

## Timing
- Reset values: out_valid=0, raw_*=0, cfg_err=0, zone=01 (inside), zone_chg=0, counter=0, candidate=inside.
- Latency: in_valid at edge N → out_valid/raw_* at edge N+2. zone/zone_chg update at edge N+3 for the accepting sample.
- Throughput: one sample per cycle; back-to-back in_valid is fully supported.
- zone_chg is high for exactly one cycle per update. Consecutive updates can produce pulses on adjacent cycles only when DEBOUNCE=1.
- Reset asserted mid-stream: all pipeline and debounce state clears immediately (asynchronously). In-flight samples are discarded, and no zone_chg is emitted on reset release.

## Configuration
- CMP_WINDOW_DEBOUNCE_EN defined: debounce counter and candidate logic present; behaviour as above.
- Not defined: DEBOUNCE is ignored. zone takes the raw zone of every valid, non-error sample at edge N+3, and zone_chg pulses whenever zone changes value. No counter or candidate registers are built. Latency is unchanged.

## Structure
- Package cmp_pkg:
  - Zone constants ZONE_BELOW=2'b00, ZONE_INSIDE=2'b01, ZONE_ABOVE=2'b10.
  - zone_t typedef.
  - Reset-zone constant.
- Sub-module cmp_debounce: parameters DEBOUNCE and WIDTH-independent. Inputs are valid and raw zone; outputs are zone and zone_chg. Counter width is $clog2(DEBOUNCE+1). The module body is conditionally compiled on CMP_WINDOW_DEBOUNCE_EN.
- Top: stage-1 registers, compare stage, cfg_err, cmp_debounce instance.

## Test plan
- Basic compare: WIDTH=8, SIGNED=0, lo=0x20, hi=0xE0; samples 0x10, 0x20, 0xE0, 0xF0 → raw below, inside, inside, above at edges N+2.
- Signed compare: SIGNED=1, lo=0xF0 (−16), hi=0x10; sample 0x80 (−128) → raw_lt; sample 0x05 → raw_in; sample 0x7F → raw_gt.
- Debounce: DEBOUNCE=4, zone inside; 3× above then 1× inside → no zone_chg. Then 4× above → zone=10, zone_chg pulse at the 4th sample's N+3.
- Gaps and candidate switching: above, above, idle for 5 cycles, above, above → zone change at the 4th valid sample. Sequence above, below, below, below, below → zone=below after the 4th below.
- Config error: lo=0x80, hi=0x40, sample 0x60 → cfg_err=1, raw_*=0, counter held. Restoring lo<hi clears cfg_err on the next sample.
- Reset mid-stream: after 3 above samples with 2 in flight, assert rst → all outputs at reset values immediately. After release, a single above sample does not change zone.
